// File: rtl/stage_sequencer_pkg.sv
// Shared types and constants for the stage sequencer: state encoding, stage bit
// positions and the wait-timer width helper.
package sequencer_pkg;

    localparam int STAGE_COUNT  = 5;
    localparam int STAGE_FETCH  = 0;
    localparam int STAGE_DECODE = 1;
    localparam int STAGE_EXEC   = 2;
    localparam int STAGE_DATA   = 3;
    localparam int STAGE_REG    = 4;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_DATA,
        ST_WRITEBACK,
        ST_HALT,
        ST_FAULT
    } state_t;

    // Working state that owns a given stage bit.
    function automatic state_t stage_state(input int idx);
        case (idx)
            STAGE_FETCH:  return ST_FETCH;
            STAGE_DECODE: return ST_DECODE;
            STAGE_EXEC:   return ST_EXECUTE;
            STAGE_DATA:   return ST_DATA;
            default:      return ST_WRITEBACK;
        endcase
    endfunction

    // A zero limit still needs a 1-bit counter so the register stays legal.
    function automatic int timer_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Decoder/memory handshake bundle between the stage sequencer and its neighbours.
interface stage_sequencer_if #(
    parameter int COUNT_WIDTH = 32
);
    import sequencer_pkg::*;

    logic                   is_memory_instr;
    logic                   is_halt;
    logic                   fetch_ready;
    logic                   data_ready;
    logic [STAGE_COUNT-1:0] stage;
    logic                   fetch_req;
    logic                   data_req;
    logic                   retire_pulse;
    logic                   halted;
    logic                   fault;
    logic [COUNT_WIDTH-1:0] retired;

    modport master (
        input  is_memory_instr, is_halt, fetch_ready, data_ready,
        output stage, fetch_req, data_req, retire_pulse, halted, fault, retired
    );

    modport slave (
        output is_memory_instr, is_halt, fetch_ready, data_ready,
        input  stage, fetch_req, data_req, retire_pulse, halted, fault, retired
    );

endinterface

// File: rtl/stage_sequencer_wait_timer.sv
// Clearable wait counter with limit compare; LIMIT of 0 never expires.
module wait_timer
    import sequencer_pkg::*;
#(
    parameter int unsigned LIMIT = 15,
    parameter int unsigned WIDTH = timer_width(LIMIT)
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    generate
        if (LIMIT == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_limit
            assign expired = (count_reg == WIDTH'(LIMIT));
        end
    endgenerate

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer with handshaked fetch/data stages, halt and timeout
// fault. Retired counter is built only when RETIRE_COUNTER_EN is defined.
module stage_sequencer
    import sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int COUNT_WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    stage_sequencer_if.master  bus
);

    state_t state_reg, state_next;
    logic   mem_pending_reg, mem_pending_next;
    logic   timer_enable;
    logic   timer_clear;
    logic   timer_expired;

    wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= ST_FETCH;
            mem_pending_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            mem_pending_reg <= mem_pending_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        mem_pending_next = mem_pending_reg;
        timer_enable     = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                timer_enable = 1'b1;
                // Ready on the limit cycle still wins over the timeout.
                if (bus.fetch_ready)     state_next = ST_DECODE;
                else if (timer_expired)  state_next = ST_FAULT;
            end
            ST_DECODE: begin
                if (bus.is_halt) begin
                    state_next = ST_HALT;
                end else begin
                    mem_pending_next = bus.is_memory_instr;
                    state_next       = ST_EXECUTE;
                end
            end
            ST_EXECUTE:   state_next = mem_pending_reg ? ST_DATA : ST_WRITEBACK;
            ST_DATA: begin
                timer_enable = 1'b1;
                if (bus.data_ready)      state_next = ST_WRITEBACK;
                else if (timer_expired)  state_next = ST_FAULT;
            end
            ST_WRITEBACK: state_next = ST_FETCH;
            ST_HALT:      state_next = ST_HALT;
            ST_FAULT:     state_next = ST_FAULT;
            default:      state_next = ST_FETCH;
        endcase
    end

    // Fresh wait budget for every state entered.
    assign timer_clear = (state_next != state_reg);

    generate
        for (genvar gi = 0; gi < STAGE_COUNT; gi++) begin : g_stage
            assign bus.stage[gi] = (state_reg == stage_state(gi));
        end
    endgenerate

    assign bus.fetch_req    = (state_reg == ST_FETCH);
    assign bus.data_req     = (state_reg == ST_DATA);
    assign bus.retire_pulse = (state_reg == ST_WRITEBACK);
    assign bus.halted       = (state_reg == ST_HALT);
    assign bus.fault        = (state_reg == ST_FAULT);

`ifdef RETIRE_COUNTER_EN
    logic [COUNT_WIDTH-1:0] retired_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            retired_reg <= '0;
        end else if (state_reg == ST_WRITEBACK) begin
            retired_reg <= retired_reg + 1'b1;
        end
    end

    assign bus.retired = retired_reg;
`else
    assign bus.retired = {COUNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Randomized scoreboard bench: an instruction-level model expands each instruction
// into expected per-cycle outputs; a monitor pops and compares them every cycle.
module tb_stage_sequencer;

    localparam int T  = 15;
    localparam int CW = 4;
`ifdef RETIRE_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]    stage;
        logic          freq;
        logic          dreq;
        logic          pulse;
        logic          halted;
        logic          fault;
        logic [CW-1:0] retired;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    stage_sequencer_if #(.COUNT_WIDTH(CW)) bus();

    stage_sequencer #(
        .MEM_TIMEOUT (T),
        .COUNT_WIDTH (CW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   model_retired = 0;
    int   txn = 0;

    // Monitor: compares one expected cycle record per clock, away from the edge.
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.stage   = bus.stage;
                a.freq    = bus.fetch_req;
                a.dreq    = bus.data_req;
                a.pulse   = bus.retire_pulse;
                a.halted  = bus.halted;
                a.fault   = bus.fault;
                a.retired = bus.retired;
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle_outputs t=%0t got stage=%b freq=%b dreq=%b pulse=%b halted=%b fault=%b retired=%0d expected stage=%b freq=%b dreq=%b pulse=%b halted=%b fault=%b retired=%0d",
                             $time, a.stage, a.freq, a.dreq, a.pulse, a.halted, a.fault, a.retired,
                             e.stage, e.freq, e.dreq, e.pulse, e.halted, e.fault, e.retired);
                end
            end
        end
    end

    task automatic scramble();
        bus.is_memory_instr = 1'($urandom);
        bus.is_halt         = 1'($urandom);
        bus.fetch_ready     = 1'($urandom);
        bus.data_ready      = 1'($urandom);
    endtask

    task automatic push_cycle(input logic [4:0] st, input logic pulse, input logic h, input logic f);
        exp_t e;
        e.stage   = st;
        e.freq    = (st == 5'b00001);
        e.dreq    = (st == 5'b01000);
        e.pulse   = pulse;
        e.halted  = h;
        e.fault   = f;
        e.retired = CNT_EN ? CW'(model_retired % (1 << CW)) : '0;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        scramble();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_retired = 0;
    endtask

    // Absorbing state: a few cycles of random inputs, then reset out of it.
    task automatic hold(input logic h, input logic f);
        for (int k = 0; k < 5; k++) begin
            scramble();
            push_cycle(5'b00000, 1'b0, h, f);
        end
        do_reset();
    endtask

    // One instruction: fw/dw are ready latencies; abort >= 0 resets during that DATA cycle.
    task automatic run_instr(input bit mem, input bit halt, input int fw, input int dw, input int abort);
        txn++;
        $display("txn %0d: mem=%0d halt=%0d fetch_wait=%0d data_wait=%0d abort=%0d retired_before=%0d",
                 txn, mem, halt, fw, dw, abort, model_retired);
        for (int i = 0; ; i++) begin
            scramble();
            if (i == fw) begin
                bus.fetch_ready = 1'b1;
                push_cycle(5'b00001, 1'b0, 1'b0, 1'b0);
                break;
            end
            bus.fetch_ready = 1'b0;
            push_cycle(5'b00001, 1'b0, 1'b0, 1'b0);
            if (T != 0 && i == T) begin
                hold(1'b0, 1'b1);
                return;
            end
        end
        scramble();
        bus.is_halt         = halt;
        bus.is_memory_instr = mem;
        push_cycle(5'b00010, 1'b0, 1'b0, 1'b0);
        if (halt) begin
            hold(1'b1, 1'b0);
            return;
        end
        scramble();
        push_cycle(5'b00100, 1'b0, 1'b0, 1'b0);
        if (mem) begin
            for (int i = 0; ; i++) begin
                scramble();
                if (i == abort) begin
                    bus.data_ready = 1'b0;
                    reset = 1'b1;
                    push_cycle(5'b01000, 1'b0, 1'b0, 1'b0);
                    reset = 1'b0;
                    model_retired = 0;
                    return;
                end
                if (i == dw) begin
                    bus.data_ready = 1'b1;
                    push_cycle(5'b01000, 1'b0, 1'b0, 1'b0);
                    break;
                end
                bus.data_ready = 1'b0;
                push_cycle(5'b01000, 1'b0, 1'b0, 1'b0);
                if (T != 0 && i == T) begin
                    hold(1'b0, 1'b1);
                    return;
                end
            end
        end
        scramble();
        push_cycle(5'b10000, 1'b1, 1'b0, 1'b0);
        model_retired++;
    endtask

    initial begin
        scramble();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_retired = 0;

        run_instr(1'b0, 1'b0, 0, 0, -1);     // ALU, zero wait
        run_instr(1'b1, 1'b0, 0, 3, -1);     // load, 3 data wait cycles
        run_instr(1'b1, 1'b1, 0, 0, -1);     // halt beats memory flag
        run_instr(1'b0, 1'b0, 200, 0, -1);   // fetch timeout
        run_instr(1'b0, 1'b0, T, 0, -1);     // ready on the limit cycle
        run_instr(1'b1, 1'b0, 2, T, -1);     // data ready on the limit cycle
        run_instr(1'b1, 1'b0, 1, 200, -1);   // data timeout
        run_instr(1'b0, 1'b0, 0, 0, -1);
        run_instr(1'b1, 1'b0, 0, 10, 2);     // reset during DATA
        run_instr(1'b0, 1'b0, 0, 0, -1);

        do_reset();
        for (int n = 0; n < 17; n++) begin   // counter wrap 15 -> 0
            run_instr(1'b0, 1'b0, int'($urandom_range(0, 2)), 0, -1);
        end

        for (int n = 0; n < 40; n++) begin
            int sel;
            sel = int'($urandom_range(0, 19));
            if (sel == 0)      run_instr(1'($urandom), 1'b1, int'($urandom_range(0, 4)), 0, -1);
            else if (sel == 1) run_instr(1'b0, 1'b0, int'($urandom_range(T + 1, T + 5)), 0, -1);
            else if (sel == 2) run_instr(1'b1, 1'b0, 0, int'($urandom_range(T + 1, T + 5)), -1);
            else if (sel == 3) run_instr(1'b1, 1'b0, 0, 8, int'($urandom_range(0, 7)));
            else               run_instr(1'($urandom), 1'b0, int'($urandom_range(0, 5)),
                                         int'($urandom_range(0, 5)), -1);
        end

        repeat (3) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Multi-cycle stage sequencer for the RISC-V core: drives the one-hot `stage` vector that enables fetch, decode, execute, data-memory and register-writeback work in turn. Replaces fixed-length stage rotation with handshaked memory stages, skips the data stage for non-memory instructions, and stops on halt instructions or memory timeouts. Sits beside the decoder and feeds `stage[data]` / `stage[reg]` to the data-memory and writeback blocks.

## Interface
- `MEM_TIMEOUT`, default 15: maximum wait cycles in FETCH or DATA before FAULT; 0 disables the timeout.
- `COUNT_WIDTH`, default 32: width of the retired-instruction counter.

- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `is_memory_instr`  in  1  decoder flag for load/store; sampled in DECODE.
- `is_halt`  in  1  decoder flag for ebreak/ecall; sampled in DECODE.
- `fetch_ready`  in  1  instruction memory has the word valid.
- `data_ready`  in  1  data memory access complete.
- `stage`  out  5  one-hot: bit0 fetch, bit1 decode, bit2 execute, bit3 data, bit4 reg (writeback).
- `fetch_req`  out  1  high throughout FETCH.
- `data_req`  out  1  high throughout DATA.
- `retire_pulse`  out  1  one-cycle pulse in WRITEBACK.
- `halted`  out  1  sticky; high in HALT.
- `fault`  out  1  sticky; high in FAULT.
- `retired`  out  COUNT_WIDTH  retired-instruction count.

## Operation
- States: FETCH, DECODE, EXECUTE, DATA, WRITEBACK, HALT, FAULT. `stage` is a Moore output: the state's bit for the five working states, 5'b0 in HALT/FAULT.
- FETCH: `fetch_ready`=1 -> DECODE; otherwise wait counter increments; counter == MEM_TIMEOUT (nonzero) with `fetch_ready`=0 -> FAULT.
- DECODE: `is_halt`=1 -> HALT (takes precedence over memory); otherwise latch `is_memory_instr` into `mem_pending`, -> EXECUTE.
- EXECUTE: `mem_pending` -> DATA, else -> WRITEBACK.
- DATA: `data_ready`=1 -> WRITEBACK; timeout as in FETCH -> FAULT.
- WRITEBACK: `retire_pulse`=1, `retired` += 1 (wraps modulo 2^COUNT_WIDTH), -> FETCH.
- HALT, FAULT: absorbing; only `reset` leaves them. Halt instruction is not counted as retired.
- Wait counter: width clog2(MEM_TIMEOUT+1), cleared on every state change; ready in the same cycle the limit is reached wins (no fault).
- Ready inputs are ignored outside their own state.

## Timing
- Reset (sync) -> next cycle: state FETCH, `stage`=5'b00001, `fetch_req`=1, `data_req`=0, `retire_pulse`=0, `halted`=0, `fault`=0, `retired`=0, `mem_pending`=0, wait counter 0.
- Zero-wait memory: ALU/branch instruction 4 cycles; load/store 5 cycles; each wait cycle adds 1.
- Fault time: FAULT entered on the edge after MEM_TIMEOUT+1 cycles in FETCH/DATA without ready.
- Reset asserted mid-instruction (any state, including DATA with request outstanding) overrides all transitions; instruction is abandoned, not counted.

## Configuration
- `RETIRE_COUNTER_EN` defined: `retired` counter register built and updated as above.
- Not defined: no counter register; `retired` tied to 0; `retire_pulse` unaffected.

## Structure
- Package `sequencer_pkg`: `state_t` enum, stage bit index constants (STAGE_FETCH=0 … STAGE_REG=4), STAGE_COUNT=5.
- Sub-module `wait_timer`: clearable counter with limit compare and disable-on-zero, instanced once and shared by FETCH and DATA.

## Test plan
- Reset then ALU instruction, both readies tied 1 -> `stage` 1,2,4,16,1; `retire_pulse` in cycle 4; `retired`=1.
- Load, `data_ready` raised after 3 wait cycles -> DATA lasts 4 cycles, `data_req` high throughout, total 8 cycles, `retired`=1.
- `is_halt`=1 in DECODE with `is_memory_instr`=1 -> HALT next cycle, `stage`=0, `halted`=1, `retired` unchanged, stays until reset.
- `fetch_ready`=0 forever, MEM_TIMEOUT=15 -> FAULT after 16 FETCH cycles; variant with `fetch_ready`=1 on 16th cycle -> DECODE, no fault.
- Reset asserted during DATA -> next cycle FETCH, `data_req`=0, `retired`=0, no `retire_pulse`.
- COUNT_WIDTH=4, 16 ALU instructions -> `retired` wraps 15 -> 0; without `RETIRE_COUNTER_EN` `retired` stays 0 while pulses still occur.
